// File: rtl/ft245_async_responder.sv
// FTDI-side model of an FT245-style async FIFO bus: answers RD#/WR# strobes from the FPGA
// FIFO controller, with host-side byte streams standing in for the USB host.
module ft245_async_responder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned RECOVER = 2
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iHostData,
    input  logic       iHostValid,
    output logic       oHostReady,
    output logic [7:0] oDevData,
    output logic       oDevValid,
    input  logic       iDevReady,
    inout  wire  [7:0] ioFifoData,
    output logic       oRxF_n,
    output logic       oTxE_n,
    input  logic       iRx_n,
    input  logic       iTx_n,
    input  logic       iSiwu,
    output logic       oProtoErr,
    output logic [7:0] oSiwuCnt
);

    localparam int unsigned CW = $clog2(RECOVER + 1);
    localparam logic [AW:0] PtrOne = 1;

    typedef enum logic [1:0] {RIdle, RReady, RBusy, RRecover} rd_state_e;
    typedef enum logic [1:0] {WIdle, WReady, WBusy, WRecover} wr_state_e;

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    logic [CW-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic [AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic          rx_n_q, rx_n_d, tx_n_q, tx_n_d, siwu_q, siwu_d;
    logic          init_q, init_d, perr_q, perr_d;
    logic [7:0]    siwu_cnt_q, siwu_cnt_d;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_fall, rx_rise, tx_fall, tx_rise, siwu_fall, both_low;
    logic rd_take, wr_take, rd_pop, host_push, dev_pop, rd_drive;
    logic [7:0] rx_head;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);

    assign rx_fall   = rx_n_q & ~iRx_n;
    assign rx_rise   = ~rx_n_q & iRx_n;
    assign tx_fall   = tx_n_q & ~iTx_n;
    assign tx_rise   = ~tx_n_q & iTx_n;
    assign siwu_fall = siwu_q & ~iSiwu;
    assign both_low  = ~iRx_n & ~iTx_n;

    // A strobe that collides with the other strobe is rejected and moves no data.
    assign rd_take = (rd_state_q == RReady) && rx_fall && !both_low;
    assign wr_take = (wr_state_q == WReady) && tx_fall && !both_low && !tx_full;

    assign rx_head    = rx_mem_q[rx_rd_q[AW-1:0]];
    assign oHostReady = init_q && !rx_full;
    assign oDevValid  = !tx_empty;
    assign oDevData   = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q[AW-1:0]];
    assign oRxF_n     = (rd_state_q != RReady);
    assign oTxE_n     = (wr_state_q != WReady);
    assign oProtoErr  = perr_q;
    assign oSiwuCnt   = siwu_cnt_q;
    assign host_push  = iHostValid && oHostReady;
    assign dev_pop    = iDevReady && oDevValid;

    // Combinational drive so the head byte is on the bus in the first RD#-low cycle.
    assign rd_drive   = !iRx_n && ((rd_state_q == RBusy) || rd_take);
    assign ioFifoData = rd_drive ? rx_head : 8'hzz;

    always_comb begin
        rd_state_d = rd_state_q;
        rcnt_d     = rcnt_q;
        rd_pop     = 1'b0;
        unique case (rd_state_q)
            RIdle:    if (!rx_empty) rd_state_d = RReady;
            RReady:   if (rd_take) rd_state_d = RBusy;
            RBusy: begin
                if (rx_rise) begin
                    rd_pop     = 1'b1;
                    rcnt_d     = CW'(RECOVER);
                    rd_state_d = RRecover;
                end
            end
            RRecover: begin
                if (rcnt_q <= CW'(1)) rd_state_d = rx_empty ? RIdle : RReady;
                else                  rcnt_d     = rcnt_q - CW'(1);
            end
            default:  rd_state_d = RIdle;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wcnt_d     = wcnt_q;
        unique case (wr_state_q)
            WIdle:    if (!tx_full) wr_state_d = WReady;
            WReady:   if (wr_take) wr_state_d = WBusy;
            WBusy: begin
                if (tx_rise) begin
                    wcnt_d     = CW'(RECOVER);
                    wr_state_d = WRecover;
                end
            end
            WRecover: begin
                if (wcnt_q <= CW'(1)) wr_state_d = tx_full ? WIdle : WReady;
                else                  wcnt_d     = wcnt_q - CW'(1);
            end
            default:  wr_state_d = WIdle;
        endcase
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        tx_mem_d = tx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        if (host_push) begin
            rx_mem_d[rx_wr_q[AW-1:0]] = iHostData;
            rx_wr_d = rx_wr_q + PtrOne;
        end
        if (rd_pop && !rx_empty) rx_rd_d = rx_rd_q + PtrOne;
        if (wr_take) begin
            tx_mem_d[tx_wr_q[AW-1:0]] = ioFifoData;
            tx_wr_d = tx_wr_q + PtrOne;
        end
        if (dev_pop) tx_rd_d = tx_rd_q + PtrOne;
    end

    always_comb begin
        rx_n_d     = iRx_n;
        tx_n_d     = iTx_n;
        siwu_d     = iSiwu;
        init_d     = 1'b1;
        perr_d     = perr_q;
        siwu_cnt_d = siwu_cnt_q;
        if ((rx_fall && rd_state_q != RReady) || (tx_fall && wr_state_q != WReady) || both_low) begin
            perr_d = 1'b1;
        end
        if (siwu_fall && siwu_cnt_q != 8'hFF) siwu_cnt_d = siwu_cnt_q + 8'd1;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            rd_state_q <= RIdle;
            wr_state_q <= WIdle;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_n_q     <= 1'b1;
            tx_n_q     <= 1'b1;
            siwu_q     <= 1'b1;
            init_q     <= 1'b0;
            perr_q     <= 1'b0;
            siwu_cnt_q <= 8'h00;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_n_q     <= rx_n_d;
            tx_n_q     <= tx_n_d;
            siwu_q     <= siwu_d;
            init_q     <= init_d;
            perr_q     <= perr_d;
            siwu_cnt_q <= siwu_cnt_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge iClk) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

endmodule
